// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types: FSM states, owners, size codes.
// Imported by the arbiter and the byte sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IC  = 1'b0,
    OWN_LSB = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] IO_TAG_DEF = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way arbiter between ICache and LSB.
// On contention the side not granted last time wins.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic ic_req_i,
  input  logic lsb_req_i,
  output logic gnt_o,
  output logic gnt_lsb_o
);

  owner_e last_q;

  assign gnt_o     = ic_req_i | lsb_req_i;
  assign gnt_lsb_o = lsb_req_i &
                     (~ic_req_i | (last_q == OWN_IC));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= OWN_IC;
    end else if (en_i && gnt_o) begin
      last_q <= gnt_lsb_o ? OWN_LSB : OWN_IC;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller shared by ICache and LSB.
// Splits 1/2/4-byte accesses, assembles reads little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_TAG = IO_TAG_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        IC_addr_sgn,
  input  logic [31:0] IC_addr,
  output logic        IC_val_sgn,
  output logic [31:0] IC_val,
  input  logic        LSB_sgn,
  input  logic        LSB_wr,
  input  logic [1:0]  LSB_size,
  input  logic [31:0] LSB_addr,
  input  logic [31:0] LSB_data,
  output logic        LSB_done,
  output logic [31:0] LSB_val
);

  state_e      state_q;
  owner_e      own_q;
  logic [2:0]  cnt_q;
  logic [2:0]  n_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic        wr_q;
  logic [31:0] a_q;
  logic [7:0]  dout_q;
  logic        ic_sgn_q;
  logic [31:0] ic_val_q;
  logic        lsb_done_q;
  logic [31:0] lsb_val_q;
  logic [7:0]  stash_q;
  logic        stash_v_q;

  logic        gnt_any;
  logic        gnt_lsb;
  logic        grant_en;
  logic [31:0] req_addr;
  logic [2:0]  req_n;
  logic        st_req;
  logic        req_blk;
  logic        cur_blk;
  logic [7:0]  din;
  logic [1:0]  rd_idx;
  logic [31:0] rd_word_d;
  logic [7:0]  wr_byte;
  logic [31:0] next_a;

  assign mem_dout   = dout_q;
  assign mem_a      = a_q;
  assign mem_wr     = wr_q & rdy;
  assign IC_val_sgn = ic_sgn_q;
  assign IC_val     = ic_val_q;
  assign LSB_done   = lsb_done_q;
  assign LSB_val    = lsb_val_q;

  assign grant_en = rdy & ~rollback & (state_q == IDLE);

  mem_ctrl_arb u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (grant_en),
    .ic_req_i  (IC_addr_sgn),
    .lsb_req_i (LSB_sgn),
    .gnt_o     (gnt_any),
    .gnt_lsb_o (gnt_lsb)
  );

  assign req_addr = gnt_lsb ? LSB_addr : IC_addr;
  assign req_n    = gnt_lsb ? size_bytes(LSB_size) : 3'd4;
  assign st_req   = gnt_lsb & LSB_wr;
  assign req_blk  = (LSB_addr[17:16] == IO_TAG) & io_buffer_full;
  assign cur_blk  = (addr_q[17:16] == IO_TAG) & io_buffer_full;

  // RAM keeps running while rdy is low, so the byte due on the
  // first frozen edge is held until the transfer resumes.
  assign din     = stash_v_q ? stash_q : mem_din;
  assign rd_idx  = cnt_q[1:0] - 2'd2;
  assign wr_byte = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign next_a  = addr_q + {29'd0, cnt_q};

  always_comb begin
    rd_word_d = rbuf_q;
    rd_word_d[{rd_idx, 3'b000} +: 8] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      own_q      <= OWN_IC;
      cnt_q      <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      wr_q       <= FALSE;
      a_q        <= '0;
      dout_q     <= '0;
      ic_sgn_q   <= FALSE;
      ic_val_q   <= '0;
      lsb_done_q <= FALSE;
      lsb_val_q  <= '0;
      stash_q    <= '0;
      stash_v_q  <= FALSE;
    end else if (!rdy) begin
      if (!stash_v_q) begin
        stash_q   <= mem_din;
        stash_v_q <= TRUE;
      end
    end else begin
      stash_v_q  <= FALSE;
      ic_sgn_q   <= FALSE;
      lsb_done_q <= FALSE;
      unique case (state_q)
        IDLE: begin
          wr_q <= FALSE;
          if (grant_en && gnt_any) begin
            addr_q  <= req_addr;
            n_q     <= req_n;
            wdata_q <= LSB_data;
            rbuf_q  <= '0;
            own_q   <= gnt_lsb ? OWN_LSB : OWN_IC;
            if (st_req) begin
              state_q <= WRITE;
              if (req_blk) begin
                cnt_q <= 3'd0;
              end else begin
                wr_q   <= TRUE;
                a_q    <= LSB_addr;
                dout_q <= LSB_data[7:0];
                cnt_q  <= 3'd1;
              end
            end else begin
              state_q <= READ;
              a_q     <= req_addr;
              cnt_q   <= 3'd1;
            end
          end
        end
        READ: begin
          if (rollback) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q >= 3'd2) rbuf_q <= rd_word_d;
            if (cnt_q < n_q) a_q <= next_a;
            if (cnt_q == n_q + 3'd1) begin
              state_q <= DONE;
              if (own_q == OWN_IC) begin
                ic_sgn_q <= TRUE;
                ic_val_q <= rd_word_d;
              end else begin
                lsb_done_q <= TRUE;
                lsb_val_q  <= rd_word_d;
              end
            end
          end
        end
        WRITE: begin
          if (cnt_q == n_q) begin
            wr_q       <= FALSE;
            lsb_done_q <= TRUE;
            state_q    <= DONE;
          end else if (cur_blk) begin
            wr_q <= FALSE;
          end else begin
            wr_q   <= TRUE;
            a_q    <= next_a;
            dout_q <= wr_byte;
            cnt_q  <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller/arbiter that shares the single byte-wide RAM port between the instruction cache (refill reads) and the load/store buffer (loads and committed stores).
- Serialises each 1/2/4-byte access into byte transactions, assembles read data little-endian, and returns a one-cycle completion pulse to the requester.
- Sits between ICache/LSB and the top-level RAM/IO pins; stalls IO-space writes while the UART buffer is full.

Parameters:
- IO_TAG, 2'b11, value of addr[17:16] that marks IO space (0x30000–0x3FFFF).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  pipeline flush; aborts speculative reads
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte; valid the cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- IC_addr_sgn  in  1  ICache refill request (level, held until served)
- IC_addr  in  32  refill word address
- IC_val_sgn  out  1  refill done, one-cycle pulse
- IC_val  out  32  refill word
- LSB_sgn  in  1  LSB request (level)
- LSB_wr  in  1  1 = store, 0 = load
- LSB_size  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word)
- LSB_addr  in  32  byte address
- LSB_data  in  32  store data, low bytes used
- LSB_done  out  1  access done, one-cycle pulse
- LSB_val  out  32  load data, zero-extended

Behaviour:
- Reset (rst high at posedge): state IDLE, cnt 0, mem_wr 0, mem_a 0, mem_dout 0, IC_val_sgn 0, IC_val 0, LSB_done 0, LSB_val 0, last_grant = IC. All outputs are registered.
- rdy low: no state, counter or output register changes. mem_wr is forced 0 combinationally.
- States: IDLE, READ, WRITE, DONE.
- IDLE, grant at edge E0 (no rollback):
  - If only one requester is active, it wins.
  - If both are active, the requester not in last_grant wins (alternation).
  - Latch addr, size n (IC always 4 bytes), data and owner; update last_grant.
  - Load or IC: go READ, mem_a <= addr.
  - Store: go WRITE; first byte is issued subject to the IO rule below.
- READ:
  - Byte k address is driven during the cycle after E_k: mem_a = addr+k, mem_wr 0.
  - mem_din is captured at E_{k+2} into bits [8k+7:8k].
  - At E_{n+1}: the owner's done/val registers are set, state goes DONE.
  - Latency from grant: word 5 edges, half 3, byte 2.
  - Unused upper bytes of LSB_val are 0.
- WRITE:
  - Byte k: mem_wr 1, mem_a = addr+k, mem_dout = data[8k+7:8k], during the cycle after E_k.
  - Done is set at E_n.
  - IO rule: if addr[17:16]==IO_TAG and io_buffer_full is 1 at an issuing edge, the byte is not issued (mem_wr 0), cnt holds, and the byte is retried at the next edge.
- DONE: pulse is high for exactly this one cycle; state returns to IDLE; requests are ignored this cycle. Requesters must drop or change their request by the end of the DONE cycle (ICache does so combinationally on IC_val_sgn).
- rollback (sampled at posedge):
  - In READ: abort to IDLE, no pulse, partial data discarded.
  - In IDLE: blocks a grant that cycle.
  - WRITE is never aborted (stores are committed).
  - If rollback coincides with the done-setting edge, the pulse is suppressed.
- Address arithmetic is 32-bit wrap-around; no alignment check.

Decomposition:
- Shared defines file: state encoding (IDLE/READ/WRITE/DONE), size codes, owner codes (IC/LSB), True/False, IO_TAG value.
- One natural sub-module: mem_ctrl_arb, a 2-way alternating-priority arbiter holding last_grant.
- Byte sequencing stays in mem_ctrl.

Test Plan:
- IC_addr 0x1000, RAM bytes 0x13,0x05,0x10,0x00 at 0x1000–0x1003 -> mem_a 0x1000..0x1003 in consecutive cycles, IC_val_sgn high one cycle at E5, IC_val 0x00100513, mem_wr never 1.
- LSB store half 0x1234BEEF at 0x2002 -> mem_wr 1 for two cycles: (0x2002, 0xEF) then (0x2003, 0xBE); LSB_done pulse at E2; no third byte.
- After reset, IC and LSB request together -> LSB load served first, then IC. Both request again -> LSB served (last_grant=IC). Check each pulse is one cycle, with an idle cycle between grants.
- Store byte 0x41 to 0x30000, io_buffer_full high for 3 edges -> mem_wr stays 0 for those cycles, then one write (0x30000, 0x41), LSB_done the cycle after.
- IC read with rollback at E2 -> IC_val_sgn never asserts; state IDLE; a new LSB byte load at 0x10 is granted next edge and completes with LSB_val = RAM[0x10] zero-extended.
- LSB word load with rdy low for 2 cycles mid-transfer -> mem_a and cnt frozen, mem_wr 0; result equals the no-stall value; completion delayed exactly 2 cycles.
